// File: rtl/wcm.sv
// WCM: timed command queue feeding the synchronizer.
// Commands are queued on SPI writes and issued in order on request.
module wcm #(
  parameter int DEPTH = 256
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        REQ_COMM,
  input  logic [63:0] TIME,
  input  logic        SYS_TIME_UPDATE,
  input  logic [47:0] FREQ,
  input  logic [47:0] FREQ_STEP,
  input  logic [31:0] FREQ_RATE,
  input  logic [63:0] TIME_START,
  input  logic [15:0] N_impulse,
  input  logic [1:0]  TYPE_impulse,
  input  logic [31:0] Interval_Ti,
  input  logic [31:0] Interval_Tp,
  input  logic [31:0] Tblank1,
  input  logic [31:0] Tblank2,
  input  logic        SPI_WR,
  output logic        DATA_WR,
  output logic [47:0] FREQ_z,
  output logic [47:0] FREQ_STEP_z,
  output logic [31:0] FREQ_RATE_z,
  output logic [63:0] TIME_START_z,
  output logic [15:0] N_impuls_z,
  output logic [1:0]  TYPE_impulse_z,
  output logic [31:0] Interval_Ti_z,
  output logic [31:0] Interval_Tp_z,
  output logic [31:0] Tblank1_z,
  output logic [31:0] Tblank2_z
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] freq_step;
    logic [31:0] freq_rate;
    logic [63:0] time_start;
    logic [15:0] n_imp;
    logic [1:0]  type_imp;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tb1;
    logic [31:0] tb2;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    OUT
  } state_t;

  cmd_t        mem [DEPTH];
  cmd_t        head;
  cmd_t        din;
  cmd_t        z;
  state_t      state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] count;
  logic        wr_q;
  logic        req_q;
  logic        sys_q;
  logic        pend;
  logic        wr_edge;
  logic        ev;
  logic        do_wr;
  logic        do_pop;
  logic        issue;

  assign din = {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse,
                TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2};

  assign wr_edge = SPI_WR & ~wr_q;
  assign ev      = (REQ_COMM & ~req_q) | (SYS_TIME_UPDATE & ~sys_q);
  assign do_wr   = wr_edge && (count != FULL);
  // The head leaves the queue in CHECK whether it is issued or stale.
  assign do_pop  = (state == CHECK);
  assign issue   = (state == CHECK) && (head.time_start > TIME);

  // Previous-value registers for rising-edge detection.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      req_q <= 1'b0;
      sys_q <= 1'b0;
    end else begin
      wr_q  <= SPI_WR;
      req_q <= REQ_COMM;
      sys_q <= SYS_TIME_UPDATE;
    end
  end

  // Queue storage and registered head read; contents survive reset.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wptr] <= din;
    if (state == READ) head <= mem[rptr];
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr)  wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pending request: set by any request edge, cleared on issue.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else if (issue) pend <= 1'b0;
    else if (ev) pend <= 1'b1;
  end

  // Issue sequencer with registered command outputs and strobe.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      DATA_WR <= 1'b0;
      z       <= '0;
    end else begin
      DATA_WR <= 1'b0;
      unique case (state)
        IDLE: if ((pend | ev) && count != '0) state <= READ;
        READ: state <= CHECK;
        CHECK: begin
          if (head.time_start <= TIME) begin
            state <= IDLE;
          end else begin
            z       <= head;
            DATA_WR <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign FREQ_z         = z.freq;
  assign FREQ_STEP_z    = z.freq_step;
  assign FREQ_RATE_z    = z.freq_rate;
  assign TIME_START_z   = z.time_start;
  assign N_impuls_z     = z.n_imp;
  assign TYPE_impulse_z = z.type_imp;
  assign Interval_Ti_z  = z.ti;
  assign Interval_Tp_z  = z.tp;
  assign Tblank1_z      = z.tb1;
  assign Tblank2_z      = z.tb2;

endmodule

// File: tb/tb_wcm.sv
// Bench for wcm: directed cases plus random traffic
// against an in-order queue model.
module tb_wcm;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic [47:0] f;
    logic [47:0] fs;
    logic [31:0] fr;
    logic [63:0] ts;
    logic [15:0] n;
    logic [1:0]  ty;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] b1;
    logic [31:0] b2;
  } cmd_t;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        REQ_COMM = 1'b0;
  logic [63:0] TIME = '0;
  logic        SYS_TIME_UPDATE = 1'b0;
  logic [47:0] FREQ = '0;
  logic [47:0] FREQ_STEP = '0;
  logic [31:0] FREQ_RATE = '0;
  logic [63:0] TIME_START = '0;
  logic [15:0] N_impulse = '0;
  logic [1:0]  TYPE_impulse = '0;
  logic [31:0] Interval_Ti = '0;
  logic [31:0] Interval_Tp = '0;
  logic [31:0] Tblank1 = '0;
  logic [31:0] Tblank2 = '0;
  logic        SPI_WR = 1'b0;
  logic        DATA_WR;
  logic [47:0] FREQ_z;
  logic [47:0] FREQ_STEP_z;
  logic [31:0] FREQ_RATE_z;
  logic [63:0] TIME_START_z;
  logic [15:0] N_impuls_z;
  logic [1:0]  TYPE_impulse_z;
  logic [31:0] Interval_Ti_z;
  logic [31:0] Interval_Tp_z;
  logic [31:0] Tblank1_z;
  logic [31:0] Tblank2_z;

  wcm #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .rst_n(rst_n), .REQ_COMM(REQ_COMM), .TIME(TIME),
    .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .FREQ(FREQ),
    .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE),
    .TIME_START(TIME_START), .N_impulse(N_impulse),
    .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
    .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2),
    .SPI_WR(SPI_WR), .DATA_WR(DATA_WR), .FREQ_z(FREQ_z),
    .FREQ_STEP_z(FREQ_STEP_z), .FREQ_RATE_z(FREQ_RATE_z),
    .TIME_START_z(TIME_START_z), .N_impuls_z(N_impuls_z),
    .TYPE_impulse_z(TYPE_impulse_z), .Interval_Ti_z(Interval_Ti_z),
    .Interval_Tp_z(Interval_Tp_z), .Tblank1_z(Tblank1_z),
    .Tblank2_z(Tblank2_z)
  );

  always #5 CLK = ~CLK;

  int   tests = 0;
  int   fails = 0;
  int   npulse = 0;
  bit   mpend = 0;
  bit   prev_dw = 0;
  cmd_t q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic cmd_t rnd_cmd(logic [63:0] ts);
    cmd_t c;
    c.f  = 48'({$urandom(), $urandom()});
    c.fs = 48'({$urandom(), $urandom()});
    c.fr = $urandom();
    c.ts = ts;
    c.n  = 16'($urandom());
    c.ty = 2'($urandom());
    c.ti = $urandom();
    c.tp = $urandom();
    c.b1 = $urandom();
    c.b2 = $urandom();
    return c;
  endfunction

  // Drop entries that are already due at the current time.
  function automatic void purge();
    while (q.size() > 0 && q[0].ts <= TIME) void'(q.pop_front());
  endfunction

  // Every issued command must be the oldest not-yet-due queued one.
  always @(negedge CLK) begin
    if (rst_n) begin
      if (DATA_WR) begin
        cmd_t got;
        npulse++;
        got = {FREQ_z, FREQ_STEP_z, FREQ_RATE_z, TIME_START_z,
               N_impuls_z, TYPE_impulse_z, Interval_Ti_z,
               Interval_Tp_z, Tblank1_z, Tblank2_z};
        tests++;
        if (prev_dw) begin
          fails++;
          $display("FAIL pulse_width: DATA_WR high 2 cycles");
        end
        purge();
        if (!mpend || q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_issue: pend=%0d q=%0d", mpend, q.size());
        end else begin
          cmd_t exp;
          exp = q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL issued_cmd: got %h expected %h", got, exp);
          end
        end
        mpend = 0;
      end
      prev_dw = DATA_WR;
    end else begin
      prev_dw = 0;
    end
  end

  task automatic wr(cmd_t c, int hold);
    FREQ = c.f; FREQ_STEP = c.fs; FREQ_RATE = c.fr;
    TIME_START = c.ts; N_impulse = c.n; TYPE_impulse = c.ty;
    Interval_Ti = c.ti; Interval_Tp = c.tp;
    Tblank1 = c.b1; Tblank2 = c.b2;
    SPI_WR = 1'b1;
    if (q.size() < DEPTH) q.push_back(c);
    repeat (hold) tick();
    SPI_WR = 1'b0;
    tick();
  endtask

  task automatic pulse_req(bit sys, int hold);
    if (sys) SYS_TIME_UPDATE = 1'b1;
    else REQ_COMM = 1'b1;
    mpend = 1;
    repeat (hold) tick();
    SYS_TIME_UPDATE = 1'b0;
    REQ_COMM = 1'b0;
    tick();
  endtask

  task automatic settle;
    repeat (3 * q.size() + 8) tick();
  endtask

  task automatic req_wait(string name);
    int base;
    bit seen;
    base = npulse;
    seen = 0;
    REQ_COMM = 1'b1;
    mpend = 1;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (npulse != base) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: no DATA_WR within 10 cycles", name);
    end
    REQ_COMM = 1'b0;
    tick();
  endtask

  initial begin
    cmd_t c;
    int   base;

    repeat (3) tick();
    check("rst_data_wr", 64'(DATA_WR), 64'd0);
    check("rst_freq_z", 64'(FREQ_z), 64'd0);
    check("rst_ts_z", TIME_START_z, 64'd0);
    check("rst_count", 64'(dut.count), 64'd0);
    rst_n = 1'b1;
    tick();

    pulse_req(0, 2);
    settle();
    check("empty_req_no_pulse", 64'(npulse), 64'd0);
    c = rnd_cmd(64'd1000000);
    c.f = 48'd43980465111040;
    c.n = 16'd10;
    wr(c, 10);
    settle();
    check("held_wr_one_pulse", 64'(npulse), 64'd1);
    check("freq_z_lit", 64'(FREQ_z), 64'd43980465111040);
    check("ts_z_lit", TIME_START_z, 64'd1000000);
    check("n_z_lit", 64'(N_impuls_z), 64'd10);

    TIME = 64'd1000;
    wr(rnd_cmd(64'd1200000), 1);
    wr(rnd_cmd(64'd1500000), 1);
    pulse_req(0, 1);
    settle();
    check("order_first", TIME_START_z, 64'd1200000);
    pulse_req(0, 1);
    settle();
    check("order_second", TIME_START_z, 64'd1500000);
    check("order_pulses", 64'(npulse), 64'd3);

    wr(rnd_cmd(64'd500), 1);
    wr(rnd_cmd(64'd1200000), 1);
    pulse_req(0, 1);
    settle();
    check("stale_pulses", 64'(npulse), 64'd4);
    check("stale_ts_z", TIME_START_z, 64'd1200000);
    check("stale_count", 64'(dut.count), 64'd0);

    wr(rnd_cmd(64'd2000000), 1);
    SYS_TIME_UPDATE = 1'b1;
    mpend = 1;
    tick();
    tick();
    check("lat_sys_c2", 64'(DATA_WR), 64'd0);
    tick();
    check("lat_sys_c3", 64'(DATA_WR), 64'd1);
    tick();
    check("lat_sys_c4", 64'(DATA_WR), 64'd0);
    SYS_TIME_UPDATE = 1'b0;
    settle();

    wr(rnd_cmd(64'd3000000), 1);
    REQ_COMM = 1'b1;
    mpend = 1;
    tick();
    rst_n = 1'b0;
    #1;
    q.delete();
    mpend = 0;
    check("midrst_data_wr", 64'(DATA_WR), 64'd0);
    check("midrst_ts_z", TIME_START_z, 64'd0);
    check("midrst_freq_z", 64'(FREQ_z), 64'd0);
    check("midrst_count", 64'(dut.count), 64'd0);
    REQ_COMM = 1'b0;
    tick();
    rst_n = 1'b1;
    base = npulse;
    repeat (8) tick();
    check("midrst_no_pulse", 64'(npulse), 64'(base));

    for (int i = 0; i < DEPTH; i++) wr(rnd_cmd(64'(2000 + i)), 1);
    check("fill_count", 64'(dut.count), 64'(DEPTH));
    wr(rnd_cmd(64'd9999), 2);
    check("full_drop_count", 64'(dut.count), 64'(DEPTH));
    check("full_wptr_wrap", 64'(dut.wptr), 64'd0);
    base = npulse;
    for (int i = 0; i < DEPTH; i++) req_wait("drain_req");
    check("drain_pulses", 64'(npulse - base), 64'(DEPTH));
    pulse_req(0, 1);
    settle();
    check("drain_extra_none", 64'(npulse - base), 64'(DEPTH));
    check("drain_rptr_wrap", 64'(dut.rptr), 64'd0);
    check("drain_count", 64'(dut.count), 64'd0);

    TIME = 64'd100000;
    for (int it = 0; it < 40; it++) begin
      int nw;
      TIME = TIME + 64'($urandom_range(0, 3000));
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        if (q.size() < DEPTH - 4)
          wr(rnd_cmd(TIME - 64'd2000 + 64'($urandom_range(0, 6000))),
             $urandom_range(1, 3));
      end
      settle();
      if ($urandom_range(0, 3) != 0)
        pulse_req(1'($urandom_range(0, 1)), $urandom_range(1, 4));
      settle();
      if (mpend) purge();
      check("rand_count", 64'(dut.count), 64'(q.size()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wcm.md
WCM -- requirements
Module: wcm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low (CLK, rst_n).
REQ-002 Parameter DEPTH, default 256: number of command-queue entries, power of two.
REQ-003 CLK  in  1  system clock, 48 MHz; all logic on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 REQ_COMM  in  1  synchronizer requests the next command; level, rising edge significant.
REQ-006 TIME  in  64  current system time, same units as TIME_START.
REQ-007 SYS_TIME_UPDATE  in  1  system time was reloaded; level, rising edge significant.
REQ-008 FREQ  in  48 / FREQ_STEP  in  48 / FREQ_RATE  in  32  command DDS fields.
REQ-009 TIME_START  in  64 / N_impulse  in  16 / TYPE_impulse  in  2  command timing fields.
REQ-010 Interval_Ti, Interval_Tp, Tblank1, Tblank2  in  32 each  command interval fields.
REQ-011 SPI_WR  in  1  write strobe; level, may be held many cycles; rising edge writes one command.
REQ-012 DATA_WR  out  1  one-cycle pulse; the *_z outputs carry a valid command.
REQ-013 FREQ_z 48, FREQ_STEP_z 48, FREQ_RATE_z 32, TIME_START_z 64, N_impuls_z 16, TYPE_impulse_z 2, Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z 32 each  out  issued command.

Function
REQ-014 Command word = concatenation of the ten input fields (338 bits), stored in a DEPTH-entry circular FIFO with write pointer, read pointer and count (0..DEPTH).
REQ-015 SPI_WR, REQ_COMM and SYS_TIME_UPDATE SHALL each be edge-detected with a 1-cycle registered previous value; no further synchronization.
REQ-016 SPI_WR rising edge in cycle N: if count<DEPTH, inputs are captured and written at write pointer; entry is visible (count incremented) in cycle N+1; if full, the write is dropped and nothing else changes.
REQ-017 Holding SPI_WR high SHALL produce exactly one write.
REQ-018 Flag pend SHALL be set by a REQ_COMM or SYS_TIME_UPDATE rising edge and cleared when a command is issued; repeated edges while pend=1 are absorbed.
REQ-019 Issue FSM states: IDLE, READ, CHECK, OUT.
REQ-020 IDLE: if pend=1 and count>0 -> READ; otherwise stay.
REQ-021 READ: registered memory read of the head entry -> CHECK.
REQ-022 CHECK: if head TIME_START <= TIME (unsigned 64-bit), discard it (pop), -> IDLE, pend kept; else -> OUT.
REQ-023 OUT: load all *_z registers from head, pop, DATA_WR=1 for this cycle only, clear pend -> IDLE.
REQ-024 Latency: with queue non-empty and a future head, DATA_WR is high exactly 3 cycles after the cycle in which the edge is detected.
REQ-025 REQ_COMM with empty queue: pend stays set; the first subsequent write is issued automatically (write visible, then +3 cycles).
REQ-026 Simultaneous write and pop in one cycle: both performed, count unchanged; a write into an empty queue is never popped in the same cycle.
REQ-027 *_z outputs SHALL hold the last issued command until the next OUT.
REQ-028 Pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-029 Commands are issued strictly in write order; no sorting by TIME_START.

Reset
REQ-030 While rst_n=0: pointers, count, pend, edge registers = 0; FSM = IDLE; DATA_WR = 0; all *_z outputs = 0.
REQ-031 Memory contents are not cleared; entries are invalid by count=0.
REQ-032 Reset mid-issue SHALL abort with no DATA_WR pulse; the queue is empty after reset.

Verification
REQ-033 Reset, then REQ_COMM rise -> no DATA_WR; SPI_WR held 10 cycles with FREQ=43980465111040, TIME_START=1000000, TIME=0 -> exactly one DATA_WR, FREQ_z=43980465111040, TIME_START_z=1000000, N_impuls_z=10.
REQ-034 Write TIME_START=1200000 then 1500000, TIME=1000; two REQ_COMM rises -> TIME_START_z 1200000 then 1500000, in order.
REQ-035 Write TIME_START=500 and 1200000, TIME=1000, REQ_COMM -> single DATA_WR with TIME_START_z=1200000; count=0 afterwards.
REQ-036 Fill DEPTH writes, one more write -> dropped; DEPTH REQ_COMMs -> DEPTH pulses, then none; pointers wrapped to 0.
REQ-037 SYS_TIME_UPDATE rise with one queued future command -> DATA_WR 3 cycles later.
REQ-038 rst_n low during READ -> no DATA_WR, all *_z = 0, count = 0.
